dmem_ctrl: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_ctrl.sv | 159 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory path: controller FSM
// states, default MMIO location, wait-counter width and RAM index sizing.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'hFFFF_0000;
    localparam int          CNT_W             = 4;

    function automatic int word_idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 data RAM: synchronous write, combinational read of the
// addressed word so the controller can capture load data on its commit edge.
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller behind the multicycle MIPS core: valid/ready request,
// programmable wait states, one MMIO result register. DMEM_ALIGN_CHECK_EN enables misalignment faults.
//
// state | meaning
// IDLE  | ready for a request; captures it on req_valid
// WAIT  | counting wait states down to the commit edge
// RESP  | rsp_valid pulse for one cycle, then back to IDLE
module dmem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] MMIO_ADDR   = MMIO_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mmio_out,
    output logic        mmio_strobe,
    output logic        busy
);

    localparam int IDX_W = word_idx_width(DEPTH);

    dmem_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             cap_we;
    logic [31:0]      cap_addr;
    logic [31:0]      cap_wdata;

    logic             commit;
    logic             acc_we;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic             is_mmio;
    logic             in_range;
    logic             misaligned;
    logic             ram_we;
    logic [31:0]      ram_rdata;
    logic [31:0]      load_data;

    // With zero wait states the access commits on the handshake edge itself,
    // so the live request fields are used instead of the captured copy.
    always_comb begin
        acc_we    = cap_we;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        commit    = 1'b0;
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            commit    = req_valid && (WAIT_CYCLES == 0);
        end else if (state == WAIT) begin
            commit    = (cnt == '0);
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |acc_addr[1:0];
`else
    logic unused_low_bits;
    assign unused_low_bits = ^acc_addr[1:0];
    assign misaligned      = 1'b0;
`endif

    assign is_mmio  = (acc_addr[31:2] == MMIO_ADDR[31:2]);
    assign in_range = (acc_addr[31:2] < 30'(DEPTH));
    assign ram_we   = commit && acc_we && !misaligned && !is_mmio && in_range && !reset;

    always_comb begin
        load_data = '0;
        if (!misaligned) begin
            if (is_mmio) begin
                load_data = mmio_out;
            end else if (in_range) begin
                load_data = ram_rdata;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            mmio_out    <= '0;
            mmio_strobe <= 1'b0;
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            mmio_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= misaligned;
                rsp_rdata <= acc_we ? 32'd0 : load_data;
                if (acc_we && is_mmio && !misaligned) begin
                    mmio_out    <= acc_wdata;
                    mmio_strobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (2 and 0 wait states) checked every cycle
// against a transaction-level memory model, plus directed literal checks.
module tb_dmem_ctrl;

    localparam logic [31:0] MMIO  = 32'hFFFF_0000;
    localparam int          DEPTH = 64;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        rv  [2];
    logic        rwe [2];
    logic        rdy [2];
    logic        vld [2];
    logic        err [2];
    logic        strb[2];
    logic        bsy [2];
    logic [31:0] ra  [2];
    logic [31:0] rwd [2];
    logic [31:0] rd  [2];
    logic [31:0] mo  [2];

    dmem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .MMIO_ADDR(MMIO)) dut_w2 (
        .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]),
        .req_we(rwe[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
        .rsp_valid(vld[0]), .rsp_rdata(rd[0]), .rsp_err(err[0]),
        .mmio_out(mo[0]), .mmio_strobe(strb[0]), .busy(bsy[0])
    );

    dmem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .MMIO_ADDR(MMIO)) dut_w0 (
        .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]),
        .req_we(rwe[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
        .rsp_valid(vld[1]), .rsp_rdata(rd[1]), .rsp_err(err[1]),
        .mmio_out(mo[1]), .mmio_strobe(strb[1]), .busy(bsy[1])
    );

    // Transaction-level model: memory contents, MMIO value, held read data and
    // the number of cycles left until the pending request must respond.
    logic [31:0] m_mem  [2][DEPTH];
    logic [31:0] m_mmio [2];
    logic [31:0] m_rdata[2];
    bit          m_busy [2];
    bit          chk_en [2];
    int          m_rem  [2];
    logic        m_we   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata[2];

    int checks = 0;
    int errors = 0;

    logic [31:0] e_rd;
    bit          e_err;
    bit          e_stb;
    bit          hs_ok;

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %h expected %h at %0t", d, name, act, exp, $time);
        end
    endtask

    task automatic resolve(input int d);
        logic [29:0] widx;
        bit          mis;
        bit          mm;
        widx  = m_addr[d][31:2];
        mis   = ALIGN && (m_addr[d][1:0] != 2'b00);
        mm    = ({widx, 2'b00} == MMIO);
        e_rd  = '0;
        e_err = mis;
        e_stb = 1'b0;
        if (!mis) begin
            if (mm) begin
                if (m_we[d]) begin
                    m_mmio[d] = m_wdata[d];
                    e_stb     = 1'b1;
                end else begin
                    e_rd = m_mmio[d];
                end
            end else if (widx < DEPTH) begin
                if (m_we[d]) m_mem[d][widx] = m_wdata[d];
                else         e_rd = m_mem[d][widx];
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            hs_ok = !m_busy[d];
            if (chk_en[d]) begin
                if (m_busy[d] && m_rem[d] == 0) begin
                    resolve(d);
                    chk(d, "rsp_valid", vld[d], 1);
                    chk(d, "req_ready", rdy[d], 0);
                    chk(d, "busy", bsy[d], 1);
                    chk(d, "rsp_rdata", rd[d], e_rd);
                    chk(d, "rsp_err", err[d], e_err);
                    chk(d, "mmio_strobe", strb[d], e_stb);
                    chk(d, "mmio_out", mo[d], m_mmio[d]);
                    m_rdata[d] = e_rd;
                    m_busy[d]  = 1'b0;
                end else begin
                    chk(d, "rsp_valid", vld[d], 0);
                    chk(d, "req_ready", rdy[d], !m_busy[d]);
                    chk(d, "busy", bsy[d], m_busy[d]);
                    chk(d, "rsp_rdata_hold", rd[d], m_rdata[d]);
                    chk(d, "mmio_strobe", strb[d], 0);
                    chk(d, "mmio_out", mo[d], m_mmio[d]);
                    if (m_busy[d]) m_rem[d]--;
                end
            end
            if (rst[d]) begin
                m_busy[d]  = 1'b0;
                m_rdata[d] = '0;
                m_mmio[d]  = '0;
                chk_en[d]  = 1'b1;
            end else if (chk_en[d] && hs_ok && rv[d]) begin
                m_busy[d]  = 1'b1;
                m_rem[d]   = wait_of(d);
                m_we[d]    = rwe[d];
                m_addr[d]  = ra[d];
                m_wdata[d] = rwd[d];
            end
        end
    end

    task automatic do_req(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic e, output int lat);
        bit got;
        @(posedge clk); #2;
        rv[d] = 1'b1; rwe[d] = we; ra[d] = addr; rwd[d] = wdata;
        @(posedge clk); #2;
        rv[d]  = 1'b0;
        rwe[d] = 1'($urandom_range(0, 1));
        ra[d]  = $urandom;
        rwd[d] = $urandom;
        lat = 0; got = 1'b0; rdata = 'x; e = 1'bx;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (vld[d]) begin
                got   = 1'b1;
                rdata = rd[d];
                e     = err[d];
            end
        end
        chk(d, "rsp_seen", got, 1);
    endtask

    task automatic do_abort(input int d, input logic [31:0] addr, input logic [31:0] wdata, input int delay);
        @(posedge clk); #2;
        rv[d] = 1'b1; rwe[d] = 1'b1; ra[d] = addr; rwd[d] = wdata;
        @(posedge clk); #2;
        rv[d] = 1'b0;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #2;
        end
        rst[d] = 1'b1;
        @(posedge clk); #2;
        rst[d] = 1'b0;
        chk(d, "abort_ready", rdy[d], 1);
        chk(d, "abort_busy", bsy[d], 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic zero_fill(input int d);
        logic [31:0] r;
        logic        e;
        int          lat;
        for (int i = 0; i < DEPTH; i++) do_req(d, 1'b1, 32'(i * 4), 32'd0, r, e, lat);
    endtask

    task automatic rand_run(input int d, input int n);
        logic [31:0] r;
        logic        e;
        int          lat;
        logic [31:0] a;
        int          sel;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = MMIO;
            else if (sel == 1) a = 32'h100 + 32'($urandom_range(0, 255)) * 4;
            else if (sel == 2) a = $urandom;
            else               a = 32'($urandom_range(0, 255));
            if (sel != 2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_req(d, 1'($urandom_range(0, 1)), a, $urandom, r, e, lat);
            chk(d, "rand_lat", lat, wait_of(d) + 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rv[d] = 1'b0; rwe[d] = 1'b0; ra[d] = '0; rwd[d] = '0;
            m_busy[d] = 1'b0; chk_en[d] = 1'b0; m_mmio[d] = '0; m_rdata[d] = '0; m_rem[d] = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[d][i] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_ready", rdy[d], 1);
            chk(d, "rst_busy", bsy[d], 0);
            chk(d, "rst_valid", vld[d], 0);
            chk(d, "rst_rdata", rd[d], 0);
            chk(d, "rst_err", err[d], 0);
            chk(d, "rst_mmio", mo[d], 0);
            chk(d, "rst_strobe", strb[d], 0);
        end

        fork
            zero_fill(0);
            zero_fill(1);
        join

        do_req(0, 1'b1, 32'h54, 32'h7, r, e, lat);
        chk(0, "st54_lat", lat, 3);
        do_req(0, 1'b0, 32'h54, 32'h0, r, e, lat);
        chk(0, "ld54_lat", lat, 3);
        chk(0, "ld54_data", r, 32'h7);
        do_req(0, 1'b1, 32'h50, 32'h0, r, e, lat);
        chk(0, "st50_err", e, 0);
        do_req(0, 1'b0, 32'h50, 32'h0, r, e, lat);
        chk(0, "ld50_data", r, 32'h0);

        do_req(0, 1'b1, 32'h400, 32'h1234, r, e, lat);
        chk(0, "oor_st_lat", lat, 3);
        chk(0, "oor_st_err", e, 0);
        do_req(0, 1'b0, 32'h400, 32'h0, r, e, lat);
        chk(0, "oor_ld_data", r, 32'h0);
        do_req(0, 1'b0, 32'h0, 32'h0, r, e, lat);
        chk(0, "oor_no_alias", r, 32'h0);

        do_req(0, 1'b1, 32'h0, 32'h11, r, e, lat);
        do_req(0, 1'b1, MMIO, 32'h1, r, e, lat);
        chk(0, "mmio_strobe_pulse", strb[0], 1);
        @(negedge clk);
        chk(0, "mmio_strobe_end", strb[0], 0);
        chk(0, "mmio_val", mo[0], 32'h1);
        do_req(0, 1'b0, 32'h0, 32'h0, r, e, lat);
        chk(0, "ram0_kept", r, 32'h11);
        do_req(0, 1'b0, MMIO, 32'h0, r, e, lat);
        chk(0, "mmio_ld", r, 32'h1);

        do_req(0, 1'b1, 32'h08, 32'hCAFE, r, e, lat);
        do_abort(0, 32'h08, 32'hAAAA_5555, 0);
        do_req(0, 1'b0, 32'h08, 32'h0, r, e, lat);
        chk(0, "abort_wait_data", r, 32'hCAFE);
        do_abort(0, 32'h08, 32'h5555_AAAA, 1);
        do_req(0, 1'b0, 32'h08, 32'h0, r, e, lat);
        chk(0, "abort_commit_data", r, 32'hCAFE);
        chk(0, "abort_mmio_clr", mo[0], 32'h0);

        do_req(0, 1'b1, 32'h04, 32'h55, r, e, lat);
        do_req(0, 1'b1, 32'h06, 32'h99, r, e, lat);
        chk(0, "st06_err", e, ALIGN);
        chk(0, "st06_lat", lat, 3);
        do_req(0, 1'b0, 32'h04, 32'h0, r, e, lat);
        chk(0, "ld04_after06", r, ALIGN ? 32'h55 : 32'h99);

        do_req(1, 1'b1, 32'h04, 32'hDEAD_BEEF, r, e, lat);
        chk(1, "w0_st_lat", lat, 1);
        chk(1, "w0_resp_ready", rdy[1], 0);
        @(negedge clk);
        chk(1, "w0_idle_ready", rdy[1], 1);
        do_req(1, 1'b0, 32'h04, 32'h0, r, e, lat);
        chk(1, "w0_ld_lat", lat, 1);
        chk(1, "w0_ld_data", r, 32'hDEAD_BEEF);

        fork
            rand_run(0, 150);
            rand_run(1, 200);
        join

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
